// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of the nibble index: ceil(log2(width/NIBBLE_W)), never below 1.
    function automatic int idx_width(input int width);
        int nib;
        nib = width / NIBBLE_W;
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit full adder shared by every nibble step.
module nibble_add4
    import serial_add_pkg::*;
(
    output logic [NIBBLE_W-1:0] sum,
    output logic                carryOut,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carryIn
);

    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carryIn};

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder sequenced one nibble per clock through a single 4-bit adder.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    state_t               state_q;
    state_t               state_d;
    logic [IW-1:0]        idx_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry_q;
    logic                 carry_out_q;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  nib_sum;
    logic                 nib_carry;
    logic                 accept;
    logic                 last_nib;

    assign accept   = (state_q == IDLE) && inValid;
    assign last_nib = (idx_q == LAST_IDX);

    assign a_nib = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    nibble_add4 u_nibble_add4 (
        .sum      (nib_sum),
        .carryOut (nib_carry),
        .a        (a_nib),
        .b        (b_nib),
        .carryIn  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inValid)  state_d = ADD;
            ADD:     if (last_nib) state_d = DONE;
            DONE:    if (outReady) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept, then one nibble of the sum per ADD cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else if (accept) begin
            a_q         <= a;
            b_q         <= b;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= carryIn;
            carry_out_q <= 1'b0;
        end else if (state_q == ADD) begin
            sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
            carry_q <= nib_carry;
            if (last_nib) begin
                idx_q       <= '0;
                carry_out_q <= nib_carry;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // The top nibble lands in sum_q on the same edge, so use nib_sum's MSB.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == ADD && last_nib) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign sum      = sum_q;
    assign carryOut = carry_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=16): vector table, corner sequences, random run.
module tb_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carryIn = 1'b0;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [W-1:0] sum;
    logic         carryOut;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .a        (a),
        .b        (b),
        .carryIn  (carryIn),
        .outValid (outValid),
        .outReady (outReady),
        .sum      (sum),
        .carryOut (carryOut),
        .busy     (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        exp_t e;
        logic [W:0] t;
        t = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (va[W-1] == vb[W-1]) && (t[W-1] != va[W-1]);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input exp_t e);
        int n;
        a = va;
        b = vb;
        carryIn = vc;
        inValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: inReady got 0 expected 1");
        end else begin
            @(posedge clk);
            #1;
            sb.push_back(e);
        end
        inValid = 1'b0;
    endtask

    task automatic collect(input int stall, output int lat);
        exp_t         e;
        logic [W-1:0] s0;
        logic         c0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid && lat < 64);
        if (!outValid) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: outValid got 0 expected 1");
            return;
        end
        s0 = sum;
        c0 = carryOut;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_sum", sum, s0);
            check("stall_cout", carryOut, c0);
            check("stall_inready", inReady, 0);
            check("stall_outvalid", outValid, 1);
        end
        outReady = 1'b1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got sum %0h expected no result", sum);
        end else begin
            e = sb.pop_front();
            check("sum", sum, e.sum);
            check("carry_out", carryOut, e.cout);
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", ovf, e.ovf);
`endif
        end
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        int           lat;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h000D, 16'h0001, 1'b1, 16'h000F, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_inready", inReady, 1);
        check("rst_outvalid", outValid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", carryOut, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        foreach (vecs[i]) begin
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            send(vecs[i].a, vecs[i].b, vecs[i].cin, e);
            collect(0, lat);
            check("latency", lat, NIB + 1);
        end

        // Backpressure: held result, second request waits for IDLE
        send(16'h0F0F, 16'h0101, 1'b0, model(16'h0F0F, 16'h0101, 1'b0));
        a = 16'h2222;
        b = 16'h1111;
        carryIn = 1'b0;
        inValid = 1'b1;
        collect(5, lat);
        @(negedge clk);
        check("bp_inready_after", inReady, 1);
        check("bp_busy_after", busy, 0);
        @(posedge clk);
        #1;
        sb.push_back(model(16'h2222, 16'h1111, 1'b0));
        inValid = 1'b0;
        check("bp_second_busy", busy, 1);
        collect(0, lat);
        check("bp_latency", lat, NIB + 1);

        // Reset mid-operation after two nibbles
        send(16'h1234, 16'h1111, 1'b0, model(16'h1234, 16'h1111, 1'b0));
        repeat (3) @(negedge clk);
        check("partial_sum", sum, 16'h0045);
        check("partial_outvalid", outValid, 0);
        #1;
        rstN = 1'b0;
        #1;
        check("midrst_outvalid", outValid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_busy", busy, 0);
        check("midrst_inready", inReady, 1);
        check("midrst_cout", carryOut, 0);
        sb.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0FFF, 16'h0001, 1'b1, model(16'h0FFF, 16'h0001, 1'b1));
        collect(1, lat);
        check("postrst_latency", lat, NIB + 1);

        // Random regression with output stalls and idle gaps
        for (int n = 0; n < 1000; n++) begin
            va = W'($urandom);
            vb = W'($urandom);
            vc = 1'($urandom);
            send(va, vb, vc, model(va, vb, vc));
            collect(int'($urandom_range(0, 3)), lat);
            check("rand_latency", lat, NIB + 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit full adder, one nibble per clock, least-significant nibble first, with the carry kept in a register. It sits between a requester and a consumer and uses valid/ready handshakes on both sides. This trades latency for area wherever wide additions are infrequent.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  rising-edge clock.
- rstN  input  1  asynchronous active-low reset.
- inValid  input  1  request valid; qualifies a, b, carryIn.
- inReady  output  1  controller can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carryIn  input  1  initial carry into nibble 0.
- outValid  output  1  result valid.
- outReady  input  1  consumer accepts the result.
- sum  output  WIDTH  result, low WIDTH bits of a+b+carryIn.
- carryOut  output  1  carry out of the top nibble.
- busy  output  1  high in ADD or DONE.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- NIB = WIDTH/4. Index register idx is ceil(log2(NIB)) bits wide.
- States:
  - IDLE: inReady=1. On inValid&inReady, latch a, b, and carryIn into the carry register; set idx=0; go to ADD.
  - ADD: the nibble adder computes {c,s} = aReg[idx] + bReg[idx] + carryReg. Write s into sum nibble idx, write c into carryReg, then idx++. After the write with idx==NIB-1, set carryOut=c and go to DONE.
  - DONE: outValid=1. Hold sum, carryOut and ovf stable until outReady, then go to IDLE.
- inReady is 0 in ADD and DONE. inValid is ignored there; the requester must hold its request.
- sum is cleared to 0 on accept, so nibbles that have not been written read as 0 during ADD.
- Arithmetic is unsigned modulo 2^WIDTH. carryOut is the true bit WIDTH of a+b+carryIn.
- Reset (asynchronous, at any time, including mid-ADD): go to IDLE; idx=0; all registers and outputs 0; the in-flight operation is discarded.

## Timing
- Reset values: inReady=1 (IDLE), outValid=0, busy=0, sum=0, carryOut=0, ovf=0.
- Accept at edge E0. Nibble k is written at edge E0+k+1. DONE is entered at edge E0+NIB, so outValid is high from cycle E0+NIB. For WIDTH=16, latency is 4 cycles.
- If outValid&outReady at edge E, the controller returns to IDLE at E, and inReady is high in the following cycle. There is no same-cycle re-accept, so peak throughput is one result per NIB+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs except inReady, which is decoded from state only.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf is registered at the DONE transition as (aReg[W-1]==bReg[W-1]) && (sum[W-1]!=aReg[W-1]).
  - It is cleared on accept and on reset.
- SERIAL_ADD_OVF_EN undefined: the ovf port and its logic are absent; everything else is identical.

## Structure
- Package serial_add_pkg contains:
  - NIBBLE_W=4;
  - state enum {IDLE, ADD, DONE} encoded 2'b00/01/10;
  - a function computing idx width from WIDTH.
- Sub-module nibble_add4: purely combinational 4-bit full adder with ports (sum[3:0], carryOut, a[3:0], b[3:0], carryIn), instantiated once.
- Nibble selection is done with an indexed part-select on aReg/bReg; no per-nibble adders.

## Test plan
- Basic add (WIDTH=16): a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, carryOut=0; outValid exactly 4 cycles after accept.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, carryOut=1, ovf=0. Also a=16'h000D, b=16'h0001, cin=1 -> sum=16'h000F.
- Signed overflow (OVF_EN): a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1. a=16'h8000, b=16'hFFFF -> sum=16'h7FFF, carryOut=1, ovf=1.
- Backpressure: hold outReady=0 for 5 cycles in DONE -> sum/carryOut stable, inReady=0, a second inValid is not accepted. Release -> IDLE the next cycle, then the second request is accepted.
- Reset mid-operation: assert rstN=0 after 2 nibbles -> immediately outValid=0, sum=0, busy=0, inReady=1. A subsequent request completes correctly.
- Random regression: 1000 random a, b, cin with random outReady stalls; compare against a WIDTH+1-bit reference adder. Repeat for WIDTH=8 and WIDTH=32.
